// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle RV32I datapath: sequences fetch/decode/execute/memory/writeback.
// Optional macro CTRL_ILLEGAL_TRAP_EN: unknown opcodes lock the FSM in TRAP and raise `illegal`.
module multicycle_ctrl #(
   parameter int ALU_CTRL_W = 4,
   parameter int STATE_W    = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [6:0]            opcode,
   input  logic [2:0]            funct3,
   input  logic                  funct7b5,
   input  logic                  zero,
   output logic                  pc_write,
   output logic                  adr_src,
   output logic                  mem_write,
   output logic                  ir_write,
   output logic                  reg_write,
   output logic [1:0]            result_src,
   output logic [1:0]            alu_src_a,
   output logic [1:0]            alu_src_b,
   output logic [2:0]            imm_src,
   output logic [ALU_CTRL_W-1:0] alu_ctrl,
   output logic                  instr_done
`ifdef CTRL_ILLEGAL_TRAP_EN
   ,
   output logic                  illegal
`endif
);

   localparam logic [ALU_CTRL_W-1:0] ALU_ADD   = ALU_CTRL_W'(4'b0000);
   localparam logic [ALU_CTRL_W-1:0] ALU_SUB   = ALU_CTRL_W'(4'b0001);
   localparam logic [ALU_CTRL_W-1:0] ALU_AND   = ALU_CTRL_W'(4'b0010);
   localparam logic [ALU_CTRL_W-1:0] ALU_OR    = ALU_CTRL_W'(4'b0011);
   localparam logic [ALU_CTRL_W-1:0] ALU_XOR   = ALU_CTRL_W'(4'b0100);
   localparam logic [ALU_CTRL_W-1:0] ALU_SLT   = ALU_CTRL_W'(4'b0101);
   localparam logic [ALU_CTRL_W-1:0] ALU_SLTU  = ALU_CTRL_W'(4'b0110);
   localparam logic [ALU_CTRL_W-1:0] ALU_AUIPC = ALU_CTRL_W'(4'b1000);
   localparam logic [ALU_CTRL_W-1:0] ALU_LUI   = ALU_CTRL_W'(4'b1001);
   localparam logic [ALU_CTRL_W-1:0] ALU_SLL   = ALU_CTRL_W'(4'b1010);
   localparam logic [ALU_CTRL_W-1:0] ALU_SRA   = ALU_CTRL_W'(4'b1011);
   localparam logic [ALU_CTRL_W-1:0] ALU_SRL   = ALU_CTRL_W'(4'b1100);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR1, S_JALR2,
      S_LUI, S_AUIPC
`ifdef CTRL_ILLEGAL_TRAP_EN
      , S_TRAP
`endif
   } state_t;

   state_t state_reg;

   function automatic logic known_opcode(input logic [6:0] op);
      return op inside {OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH,
                        OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
   endfunction

   // Shared funct3 decode for register and immediate ALU ops; only R-type may subtract.
   function automatic logic [ALU_CTRL_W-1:0] exec_op(input logic [2:0] f3, input logic f7b5,
                                                     input logic is_r);
      case (f3)
         3'b000:  return (is_r && f7b5) ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return f7b5 ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= S_FETCH;
      end else begin
         case (state_reg)
            S_FETCH:  state_reg <= S_DECODE;
            S_DECODE: begin
               case (opcode)
                  OP_LOAD, OP_STORE: state_reg <= S_MEMADR;
                  OP_RTYPE:          state_reg <= S_EXECR;
                  OP_ITYPE:          state_reg <= S_EXECI;
                  OP_BRANCH:         state_reg <= S_BRANCH;
                  OP_JAL:            state_reg <= S_JAL;
                  OP_JALR:           state_reg <= S_JALR1;
                  OP_LUI:            state_reg <= S_LUI;
                  OP_AUIPC:          state_reg <= S_AUIPC;
`ifdef CTRL_ILLEGAL_TRAP_EN
                  default:           state_reg <= S_TRAP;
`else
                  default:           state_reg <= S_FETCH;
`endif
               endcase
            end
            S_MEMADR:   state_reg <= opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_reg <= S_MEMWB;
            S_EXECR:    state_reg <= S_ALUWB;
            S_EXECI:    state_reg <= S_ALUWB;
            S_JAL:      state_reg <= S_ALUWB;
            S_JALR1:    state_reg <= S_JALR2;
            S_JALR2:    state_reg <= S_ALUWB;
            S_LUI:      state_reg <= S_ALUWB;
            S_AUIPC:    state_reg <= S_ALUWB;
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_TRAP:     state_reg <= S_TRAP;
`endif
            default:    state_reg <= S_FETCH;
         endcase
      end
   end

   always_comb begin
      case (opcode)
         OP_STORE:         imm_src = 3'b001;
         OP_BRANCH:        imm_src = 3'b010;
         OP_JAL:           imm_src = 3'b011;
         OP_LUI, OP_AUIPC: imm_src = 3'b100;
         default:          imm_src = 3'b000;
      endcase
   end

   always_comb begin
      pc_write   = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      result_src = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_ctrl   = ALU_ADD;
      instr_done = 1'b0;
      case (state_reg)
         S_FETCH: begin
            ir_write = 1'b1; pc_write = 1'b1;
            alu_src_b = 2'b10; result_src = 2'b10;
         end
         S_DECODE: begin
            alu_src_a = 2'b01; alu_src_b = 2'b01;
            instr_done = ~known_opcode(opcode);
`ifdef CTRL_ILLEGAL_TRAP_EN
            instr_done = 1'b0;
`endif
         end
         S_MEMADR:   begin alu_src_a = 2'b10; alu_src_b = 2'b01; end
         S_MEMREAD:  adr_src = 1'b1;
         S_MEMWB:    begin result_src = 2'b01; reg_write = 1'b1; instr_done = 1'b1; end
         S_MEMWRITE: begin adr_src = 1'b1; mem_write = 1'b1; instr_done = 1'b1; end
         S_EXECR: begin
            alu_src_a = 2'b10; alu_src_b = 2'b00;
            alu_ctrl = exec_op(funct3, funct7b5, 1'b1);
         end
         S_EXECI: begin
            alu_src_a = 2'b10; alu_src_b = 2'b01;
            alu_ctrl = exec_op(funct3, funct7b5, 1'b0);
         end
         S_ALUWB:    begin reg_write = 1'b1; instr_done = 1'b1; end
         S_BRANCH: begin
            // zero is live from the ALU this cycle, so pc_write is the only Mealy output.
            alu_src_a = 2'b10; instr_done = 1'b1;
            case (funct3)
               3'b000:  begin alu_ctrl = ALU_SUB;  pc_write = zero;  end
               3'b001:  begin alu_ctrl = ALU_SUB;  pc_write = ~zero; end
               3'b100:  begin alu_ctrl = ALU_SLT;  pc_write = ~zero; end
               3'b101:  begin alu_ctrl = ALU_SLT;  pc_write = zero;  end
               3'b110:  begin alu_ctrl = ALU_SLTU; pc_write = ~zero; end
               3'b111:  begin alu_ctrl = ALU_SLTU; pc_write = zero;  end
               default: pc_write = 1'b0;
            endcase
         end
         S_JAL:      begin alu_src_a = 2'b01; alu_src_b = 2'b10; pc_write = 1'b1; end
         S_JALR1:    begin alu_src_a = 2'b10; alu_src_b = 2'b01; end
         S_JALR2:    begin alu_src_a = 2'b01; alu_src_b = 2'b10; pc_write = 1'b1; end
         S_LUI:      begin alu_src_b = 2'b01; alu_ctrl = ALU_LUI; end
         S_AUIPC:    begin alu_src_a = 2'b01; alu_src_b = 2'b01; alu_ctrl = ALU_AUIPC; end
         default:    ;
      endcase
      if (reset) begin
         pc_write = 1'b0; ir_write = 1'b0; mem_write = 1'b0;
         reg_write = 1'b0; instr_done = 1'b0;
      end
   end

`ifdef CTRL_ILLEGAL_TRAP_EN
   assign illegal = (state_reg == S_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: instruction table, reset/trap sequences and random instructions
// checked cycle-by-cycle against a per-instruction trace model.
module tb_multicycle_ctrl;
   logic clk = 1'b0;
   logic reset;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic funct7b5, zero;
   logic pc_write, adr_src, mem_write, ir_write, reg_write, instr_done;
   logic [1:0] result_src, alu_src_a, alu_src_b;
   logic [2:0] imm_src;
   logic [3:0] alu_ctrl;
`ifdef CTRL_ILLEGAL_TRAP_EN
   logic illegal;
`endif

   multicycle_ctrl #(.ALU_CTRL_W(4), .STATE_W(4)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
      .zero(zero), .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
      .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
      .alu_ctrl(alu_ctrl), .instr_done(instr_done)
`ifdef CTRL_ILLEGAL_TRAP_EN
      , .illegal(illegal)
`endif
   );

   always #5 clk = ~clk;

   localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, AND_ = 4'b0010, OR_ = 4'b0011,
      XOR_ = 4'b0100, SLT = 4'b0101, SLTU = 4'b0110, AUIPC = 4'b1000, LUI = 4'b1001,
      SLL = 4'b1010, SRA = 4'b1011, SRL = 4'b1100;

   int n_vec = 0;
   int n_err = 0;
   logic [18:0] exp_q[$];

   function automatic logic [18:0] mk(input logic pcw, adr, mw, irw, rw,
                                      input logic [1:0] rs, a, b, input logic [3:0] alu,
                                      input logic done, input logic [2:0] imm);
      return {pcw, adr, mw, irw, rw, rs, a, b, imm, alu, done};
   endfunction

   function automatic logic [18:0] got_word();
      return {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
              alu_src_a, alu_src_b, imm_src, alu_ctrl, instr_done};
   endfunction

   function automatic logic [2:0] imm_of(input logic [6:0] op);
      case (op)
         7'b0100011: return 3'b001;
         7'b1100011: return 3'b010;
         7'b1101111: return 3'b011;
         7'b0110111, 7'b0010111: return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   // ALU operation meaning of funct3 for arithmetic instructions.
   function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic f7, input logic is_r);
      case (f3)
         3'd0: return (is_r && f7) ? SUB : ADD;
         3'd1: return SLL;
         3'd2: return SLT;
         3'd3: return SLTU;
         3'd4: return XOR_;
         3'd5: return f7 ? SRA : SRL;
         3'd6: return OR_;
         default: return AND_;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Expected output trace, one word per cycle, for a whole instruction.
   task automatic build_trace(input logic [31:0] ins, input logic z);
      logic [6:0] op = ins[6:0];
      logic [2:0] f3 = ins[14:12];
      logic f7 = ins[30];
      logic [2:0] im = imm_of(op);
      logic [18:0] wb = mk(0,0,0,0,1,2'b00,2'b00,2'b00,ADD,1,im);
      logic [3:0] balu;
      logic taken;
      exp_q.delete();
      exp_q.push_back(mk(1,0,0,1,0,2'b10,2'b00,2'b10,ADD,0,im));
      case (op)
         7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111,
         7'b1100111, 7'b0110111, 7'b0010111:
            exp_q.push_back(mk(0,0,0,0,0,2'b00,2'b01,2'b01,ADD,0,im));
         default:
            exp_q.push_back(mk(0,0,0,0,0,2'b00,2'b01,2'b01,ADD,1,im));
      endcase
      case (op)
         7'b0000011: begin
            exp_q.push_back(mk(0,0,0,0,0,2'b00,2'b10,2'b01,ADD,0,im));
            exp_q.push_back(mk(0,1,0,0,0,2'b00,2'b00,2'b00,ADD,0,im));
            exp_q.push_back(mk(0,0,0,0,1,2'b01,2'b00,2'b00,ADD,1,im));
         end
         7'b0100011: begin
            exp_q.push_back(mk(0,0,0,0,0,2'b00,2'b10,2'b01,ADD,0,im));
            exp_q.push_back(mk(0,1,1,0,0,2'b00,2'b00,2'b00,ADD,1,im));
         end
         7'b0110011: begin
            exp_q.push_back(mk(0,0,0,0,0,2'b00,2'b10,2'b00,arith_op(f3,f7,1),0,im));
            exp_q.push_back(wb);
         end
         7'b0010011: begin
            exp_q.push_back(mk(0,0,0,0,0,2'b00,2'b10,2'b01,arith_op(f3,f7,0),0,im));
            exp_q.push_back(wb);
         end
         7'b1100011: begin
            // zero means rs1==rs2 for sub, and "comparison false" for slt/sltu.
            case (f3)
               3'd0: begin balu = SUB;  taken = z;  end
               3'd1: begin balu = SUB;  taken = !z; end
               3'd4: begin balu = SLT;  taken = !z; end
               3'd5: begin balu = SLT;  taken = z;  end
               3'd6: begin balu = SLTU; taken = !z; end
               3'd7: begin balu = SLTU; taken = z;  end
               default: begin balu = ADD; taken = 0; end
            endcase
            exp_q.push_back(mk(taken,0,0,0,0,2'b00,2'b10,2'b00,balu,1,im));
         end
         7'b1101111: begin
            exp_q.push_back(mk(1,0,0,0,0,2'b00,2'b01,2'b10,ADD,0,im));
            exp_q.push_back(wb);
         end
         7'b1100111: begin
            exp_q.push_back(mk(0,0,0,0,0,2'b00,2'b10,2'b01,ADD,0,im));
            exp_q.push_back(mk(1,0,0,0,0,2'b00,2'b01,2'b10,ADD,0,im));
            exp_q.push_back(wb);
         end
         7'b0110111: begin
            exp_q.push_back(mk(0,0,0,0,0,2'b00,2'b00,2'b01,LUI,0,im));
            exp_q.push_back(wb);
         end
         7'b0010111: begin
            exp_q.push_back(mk(0,0,0,0,0,2'b00,2'b01,2'b01,AUIPC,0,im));
            exp_q.push_back(wb);
         end
         default: ;
      endcase
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Entered with the DUT in FETCH, shortly after a rising edge.
   task automatic run_instr(input logic [31:0] ins, input logic z, input string name,
                            output int ncyc, output logic [3:0] alu2);
      int bad = 0;
      logic [18:0] got;
      opcode = ins[6:0]; funct3 = ins[14:12]; funct7b5 = ins[30]; zero = z;
      build_trace(ins, z);
      ncyc = 99; alu2 = 4'hF;
      for (int k = 0; k < exp_q.size(); k++) begin
         @(negedge clk);
         got = got_word();
         n_vec++;
         if (got !== exp_q[k]) begin
            n_err++; bad = 1;
            $display("FAIL %s cycle %0d: got %h expected %h", name, k, got, exp_q[k]);
         end
         if (k == 2) alu2 = alu_ctrl;
         if (instr_done === 1'b1 && ncyc == 99) ncyc = k + 1;
         @(posedge clk);
         #1;
      end
      if (bad != 0) do_reset();
   endtask

   typedef struct {
      logic [31:0] instr;
      logic        z;
      int          cycles;
      logic [3:0]  alu2;
      logic [2:0]  imm;
      string       name;
   } vec_t;

   vec_t vecs[15];
   logic [6:0] ops[10];

   initial begin
      int nc;
      logic [3:0] a2;
      logic [31:0] ins;
      reset = 1'b1; opcode = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0;

      vecs[0]  = '{32'h002081B3, 0, 4, ADD,   3'b000, "add"};
      vecs[1]  = '{32'h402081B3, 0, 4, SUB,   3'b000, "sub"};
      vecs[2]  = '{32'h40005013, 0, 4, SRA,   3'b000, "srai"};
      vecs[3]  = '{32'h00005013, 0, 4, SRL,   3'b000, "srli"};
      vecs[4]  = '{32'h40000013, 0, 4, ADD,   3'b000, "addi_f7"};
      vecs[5]  = '{32'h0000A183, 0, 5, ADD,   3'b000, "lw"};
      vecs[6]  = '{32'h0030A023, 0, 4, ADD,   3'b001, "sw"};
      vecs[7]  = '{32'h00000063, 1, 3, SUB,   3'b010, "beq_z1"};
      vecs[8]  = '{32'h00006063, 1, 3, SLTU,  3'b010, "bltu_z1"};
      vecs[9]  = '{32'h00006063, 0, 3, SLTU,  3'b010, "bltu_z0"};
      vecs[10] = '{32'h000000EF, 0, 4, ADD,   3'b011, "jal"};
      vecs[11] = '{32'h000080E7, 0, 5, ADD,   3'b000, "jalr"};
      vecs[12] = '{32'h000001B7, 0, 4, LUI,   3'b100, "lui"};
      vecs[13] = '{32'h00000197, 0, 4, AUIPC, 3'b100, "auipc"};
      vecs[14] = '{32'h0020B1B3, 0, 4, SLTU,  3'b000, "sltu"};

      #3;
      check("reset_state", 32'(got_word()), 32'(mk(0,0,0,0,0,2'b10,2'b00,2'b10,ADD,0,3'b000)));
      do_reset();

      foreach (vecs[i]) begin
         run_instr(vecs[i].instr, vecs[i].z, vecs[i].name, nc, a2);
         check({vecs[i].name, "_cycles"}, 32'(nc), 32'(vecs[i].cycles));
         check({vecs[i].name, "_alu"}, 32'(a2), 32'(vecs[i].alu2));
         check({vecs[i].name, "_imm"}, 32'(imm_src), 32'(vecs[i].imm));
      end

      // Reset asserted in the middle of EXECR.
      opcode = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("execr_mux", 32'({alu_src_a, alu_src_b}), 32'(4'b1000));
      #2 reset = 1'b1;
      #1 check("reset_async", 32'(got_word()), 32'(mk(0,0,0,0,0,2'b10,2'b00,2'b10,ADD,0,3'b000)));
      @(posedge clk); @(negedge clk);
      check("reset_hold", 32'(got_word()), 32'(mk(0,0,0,0,0,2'b10,2'b00,2'b10,ADD,0,3'b000)));
      reset = 1'b0;
      #1 check("release_fetch", 32'(got_word()), 32'(mk(1,0,0,1,0,2'b10,2'b00,2'b10,ADD,0,3'b000)));
      @(posedge clk); #1;
      check("release_decode", 32'({alu_src_a, alu_src_b, ir_write}), 32'(5'b01010));
      do_reset();

`ifdef CTRL_ILLEGAL_TRAP_EN
      opcode = 7'h7F; funct3 = '0; funct7b5 = 1'b0;
      @(posedge clk); #1;
      check("trap_decode_done", 32'(instr_done), 32'(0));
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check("trap_hold", 32'({illegal, pc_write, ir_write, mem_write, reg_write, instr_done}),
               32'(6'b100000));
      end
      do_reset();
      check("trap_cleared", 32'(illegal), 32'(0));
`else
      run_instr(32'h0000007F, 0, "illegal_nop", nc, a2);
      check("illegal_nop_cycles", 32'(nc), 32'(2));
`endif

      ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
              7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};
      for (int r = 0; r < 250; r++) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
         ins = 32'(ops[$urandom_range(0, 8)]);
`else
         ins = 32'(ops[$urandom_range(0, 9)]);
`endif
         ins[14:12] = 3'($urandom_range(0, 7));
         ins[30] = 1'($urandom_range(0, 1));
         run_instr(ins, 1'($urandom_range(0, 1)), "random", nc, a2);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control FSM for the multi-cycle RV32I datapath. It is the issuing end of the ALU interface.
- Decodes the instruction register fields and sequences each instruction through fetch/decode/execute/memory/writeback states.
- Drives datapath muxes, write enables and alu_ctrl every cycle; samples the ALU zero flag to resolve branches.

Parameters:
- ALU_CTRL_W, 4, width of alu_ctrl.
- STATE_W, 4, width of the state register.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- opcode  input  7  instr[6:0] from the instruction register.
- funct3  input  3  instr[14:12].
- funct7b5  input  1  instr[30].
- zero  input  1  ALU zero flag, combinational from the current alu_ctrl/operands.
- pc_write  output  1  PC register load enable.
- adr_src  output  1  memory address select: 0=PC, 1=ALUOut.
- mem_write  output  1  data memory write enable.
- ir_write  output  1  instruction register / OldPC load enable.
- reg_write  output  1  register file write enable.
- result_src  output  2  result mux: 00=ALUOut, 01=mem data, 10=ALU output direct.
- alu_src_a  output  2  A-operand mux: 00=PC, 01=OldPC, 10=rs1 reg.
- alu_src_b  output  2  B-operand mux: 00=rs2 reg, 01=imm, 10=constant 4.
- imm_src  output  3  immediate type: 000=I, 001=S, 010=B, 011=J, 100=U.
- alu_ctrl  output  4  ALU operation code.
- instr_done  output  1  one-cycle pulse in the final cycle of each instruction.

Behaviour:
- Single clock. Reset is asynchronous, active-high: state <= FETCH immediately.
- While reset is high, pc_write, ir_write, mem_write, reg_write and instr_done are forced 0. Other outputs take their FETCH values.
- alu_ctrl encoding is fixed: add 0000, sub 0001, and 0010, or 0011, xor 0100, slt 0101, sltu 0110, auipc 1000, lui 1001, sll 1010, sra 1011, srl 1100.
- Outputs are a Moore function of state, except pc_write in BRANCH. Outputs not listed for a state are 0 / 00.
- imm_src is decoded combinationally from opcode only, independent of state. Unknown opcode gives 000.
- FETCH: adr_src=0, ir_write=1, a=00, b=10, alu_ctrl=add, result_src=10, pc_write=1. Next: DECODE.
- DECODE: a=01, b=01, add (ALUOut <= branch/jal target). Next state by opcode:
  - 0000011 / 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR1
  - 0110111 -> LUI
  - 0010111 -> AUIPC
  - other -> see optional feature
- MEMADR: a=10, b=01, add. Next: MEMREAD if opcode[5]=0, else MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Next: MEMWB.
- MEMWB: result_src=01, reg_write=1, instr_done=1. Next: FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1, instr_done=1. Next: FETCH.
- EXECR: a=10, b=00, alu_ctrl from funct3 decode. Next: ALUWB.
- EXECI: a=10, b=01, alu_ctrl from funct3 decode. Next: ALUWB.
- funct3 decode (EXECR/EXECI):
  - 000: sub if EXECR and funct7b5, else add
  - 001: sll
  - 010: slt
  - 011: sltu
  - 100: xor
  - 101: sra if funct7b5, else srl (both R and I)
  - 110: or
  - 111: and
- ALUWB: result_src=00, reg_write=1, instr_done=1. Next: FETCH.
- BRANCH: a=10, b=00, result_src=00, instr_done=1. Next: FETCH. alu_ctrl and pc_write by funct3:
  - beq 000: sub, pc_write=zero
  - bne 001: sub, pc_write=~zero
  - blt 100: slt, pc_write=~zero
  - bge 101: slt, pc_write=zero
  - bltu 110: sltu, pc_write=~zero
  - bgeu 111: sltu, pc_write=zero
  - 010/011: pc_write=0 (not taken)
- JAL: a=01, b=10, add, result_src=00, pc_write=1. Next: ALUWB (writes OldPC+4).
- JALR1: a=10, b=01, add (ALUOut <= rs1+imm). Next: JALR2.
- JALR2: a=01, b=10, add, result_src=00, pc_write=1. Next: ALUWB.
- LUI: b=01, alu_ctrl=lui. Next: ALUWB.
- AUIPC: a=01, b=01, alu_ctrl=auipc. Next: ALUWB.
- Cycle counts: load 5, store 4, R/I-ALU 4, branch 3, jal 4, jalr 5, lui/auipc 4.
- Reset mid-instruction: the instruction is abandoned, no write enable asserts, and FETCH runs on the first clock after deassertion.
- Undefined state encodings return to FETCH.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined: an unknown opcode in DECODE goes to TRAP. TRAP holds all enables 0 and never exits until reset. Adds output port illegal (1 bit), high only in TRAP.
- Undefined: an unknown opcode in DECODE goes to FETCH with instr_done=1 in that DECODE cycle, i.e. it executes as a NOP. No illegal port exists.

Test Plan:
- Reset asserted mid-EXECR -> state is FETCH asynchronously; all write enables 0 during reset; ir_write=1 and pc_write=1 on the first cycle after release.
- add x3,x1,x2 (0x002081B3) -> FETCH, DECODE, EXECR (alu_ctrl=0000, a=10, b=00), ALUWB (reg_write=1, instr_done=1); 4 cycles. sub (0x402081B3) gives alu_ctrl=0001.
- srai (opcode 0010011, funct3 101, funct7b5=1) -> EXECI alu_ctrl=1011. Same with funct7b5=0 -> 1100. addi with funct7b5=1 -> 0000.
- lw (0x0000A183) -> 5 cycles; MEMREAD adr_src=1; MEMWB result_src=01, reg_write=1. sw (0x0030A023) -> MEMWRITE mem_write=1 on cycle 4, imm_src=001.
- beq with zero=1 -> BRANCH alu_ctrl=0001, pc_write=1. bltu with zero=1 -> alu_ctrl=0110, pc_write=0. Both take 3 cycles.
- jalr (0x000080E7) -> JALR1 a=10/b=01, then JALR2 pc_write=1 a=01/b=10, then ALUWB reg_write=1. Opcode 0x7F: with CTRL_ILLEGAL_TRAP_EN, illegal=1 held; without it, back to FETCH after DECODE.
